// File: rtl/aes_decrypt_iter.sv
// rtl/aes_decrypt_iter.sv - iterative AES inverse cipher, one inverse round per clock
// Round keys come from the packed expanded-key bus, walked from rk[nr] down to rk[0].

module inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [2047:0] TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };
  logic [10:0] idx;
  assign idx = 11'd2047 - {a, 3'b000};
  assign y   = TBL[idx -: 8];
endmodule

module aes_decrypt_iter #(
  parameter int KEYBUS_W = 1920
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [1:0]          switch,
  input  logic [127:0]        in,
  input  logic [KEYBUS_W-1:0] key_d,
  output logic [127:0]        out,
  output logic                busy,
  output logic                done
);
  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

  state_t       state, state_nxt;
  logic [127:0] st, rk, isr, isb, ark, imc;
  logic [3:0]   cnt, nr, nr_sel, slot_idx;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiples 9/b/d/e built from the x2/x4/x8 chain of each byte.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0]  a [4];
    logic [7:0]  x2 [4];
    logic [7:0]  x4 [4];
    logic [7:0]  x8 [4];
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
    end
    for (int r = 0; r < 4; r++) begin
      res[31-8*r -: 8] = (x8[r] ^ x4[r] ^ x2[r])
                       ^ (x8[(r+1)%4] ^ x2[(r+1)%4] ^ a[(r+1)%4])
                       ^ (x8[(r+2)%4] ^ x4[(r+2)%4] ^ a[(r+2)%4])
                       ^ (x8[(r+3)%4] ^ a[(r+3)%4]);
    end
    return res;
  endfunction

  always_comb begin
    case (switch)
      2'b00:   nr_sel = 4'd10;
      2'b01:   nr_sel = 4'd12;
      default: nr_sel = 4'd14;
    endcase
  end

  // Slot 0 holds rk[nr]; rk[cnt] lives in slot nr-cnt, rk[0] in slot nr.
  always_comb begin
    case (state)
      IDLE:    slot_idx = 4'd0;
      FINAL:   slot_idx = nr;
      default: slot_idx = nr - cnt;
    endcase
  end

  assign rk = key_d[{slot_idx, 7'b0000000} +: 128];

  for (genvar k = 0; k < 16; k++) begin : g_byte
    localparam int R   = k % 4;
    localparam int C   = k / 4;
    localparam int SRC = 4 * ((C - R + 4) % 4) + R;
    assign isr[127-8*k -: 8] = st[127-8*SRC -: 8];
    inv_sbox u_inv_sbox (.a(isr[127-8*k -: 8]), .y(isb[127-8*k -: 8]));
  end

  assign ark = isb ^ rk;

  for (genvar c = 0; c < 4; c++) begin : g_col
    assign imc[127-32*c -: 32] = inv_mix_col(ark[127-32*c -: 32]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ROUND;
      ROUND:   if (cnt == 4'd1) state_nxt = FINAL;
      FINAL:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st   <= '0;
      cnt  <= '0;
      nr   <= '0;
      out  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          st   <= in ^ rk;
          cnt  <= nr_sel - 4'd1;
          nr   <= nr_sel;
          busy <= 1'b1;
        end
        ROUND: begin
          st  <= imc;
          cnt <= cnt - 4'd1;
        end
        FINAL: begin
          st   <= ark;
          out  <= ark;
          done <= 1'b1;
          busy <= 1'b0;
        end
        DONE: done <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule
